// File: rtl/rand_pkg.sv
// rand_pkg: pair-compare encoding and width helper shared by the random-bit blocks
package rand_pkg;
  typedef enum logic [1:0] {PAIR_NONE = 2'b00, PAIR_ONE = 2'b01, PAIR_ZERO = 2'b10} pair_e;
  function automatic pair_e pair_cmp(input logic [1:0] first, input logic [1:0] second);
    return first > second ? PAIR_ONE : first < second ? PAIR_ZERO : PAIR_NONE;
  endfunction
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rand_word_collector_if.sv
// rand_word_collector_if: raw race inputs, word handshake and health/drop status
interface rand_word_collector_if #(parameter int NUM_CH = 4, parameter int WORD_W = 32, parameter int DROP_W = 16);
  logic [NUM_CH-1:0] raw_a, raw_b, raw_valid, adjusting;
  logic [WORD_W-1:0] out_word;
  logic out_valid, out_ready, health_fail, health_clr;
  logic [DROP_W-1:0] drop_cnt;
  modport master (output raw_a, raw_b, raw_valid, adjusting, out_ready, health_clr,
                  input out_word, out_valid, health_fail, drop_cnt);
  modport slave (input raw_a, raw_b, raw_valid, adjusting, out_ready, health_clr,
                 output out_word, out_valid, health_fail, drop_cnt);
endinterface

// File: rtl/rand_vn_filter.sv
// rand_vn_filter: per-channel pairwise debias filter with a 1-bit output buffer
module rand_vn_filter
  import rand_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  input  logic valid,
  input  logic adjusting,
  input  logic grant,
  output logic buf_v,
  output logic buf_b,
  output logic drop
);
  logic held, la, lb, emit;
  pair_e pc;
  always_comb begin
    pc = pair_cmp({la, lb}, {a, b});
    emit = valid && !adjusting && held && pc != PAIR_NONE;
    drop = emit && buf_v && !grant;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      held <= 1'b0;
      la <= 1'b0;
      lb <= 1'b0;
      buf_v <= 1'b0;
      buf_b <= 1'b0;
    end else begin
      // second half of a pair also lands in la/lb but is never compared
      if (adjusting) held <= 1'b0;
      else if (valid) begin
        held <= !held;
        la <= a;
        lb <= b;
      end
      if (emit && !drop) begin
        buf_v <= 1'b1;
        buf_b <= pc == PAIR_ONE;
      end else if (grant) buf_v <= 1'b0;
    end
endmodule

// File: rtl/rand_word_collector.sv
// rand_word_collector: debiases NUM_CH race channels, packs bits round-robin into words
module rand_word_collector
  import rand_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WORD_W = 32,
  parameter int REPEAT_LIMIT = 24,
  parameter int DROP_W = 16
) (
  input logic clk,
  input logic rst_n,
  rand_word_collector_if.slave bus
);
  localparam int CW = clog2(WORD_W + 1);
  localparam int PW = NUM_CH > 1 ? clog2(NUM_CH) : 1;
  logic [NUM_CH-1:0] buf_v, buf_b, drop, grant;
  logic [PW-1:0] ptr, gidx;
  logic [CW-1:0] cnt, cnt_n;
  logic [WORD_W-1:0] sh, sh_n;
  logic [7:0] rep, rep_n;
  logic [DROP_W:0] dsum, dnext;
  logic found, full, out_free, take, gbit, ld_full, ld_new, last;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    rand_vn_filter u_filter (
      .clk(clk), .rst_n(rst_n), .a(bus.raw_a[i]), .b(bus.raw_b[i]), .valid(bus.raw_valid[i]),
      .adjusting(bus.adjusting[i]), .grant(grant[i]), .buf_v(buf_v[i]), .buf_b(buf_b[i]), .drop(drop[i])
    );
  end
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (!found && buf_v[(int'(ptr) + i) % NUM_CH]) begin
        found = 1'b1;
        gidx = PW'((int'(ptr) + i) % NUM_CH);
      end
    full = cnt == CW'(WORD_W);
    out_free = !bus.out_valid || bus.out_ready;
    take = found && (!full || out_free);
    gbit = buf_b[gidx];
    grant = take ? NUM_CH'(1) << gidx : '0;
    sh_n = take ? {sh[WORD_W-2:0], gbit} : sh;
    ld_full = full && out_free;
    cnt_n = (ld_full ? CW'(0) : cnt) + CW'(take);
    ld_new = !full && cnt_n == CW'(WORD_W) && out_free;
    rep_n = (rep != 8'd0 && gbit == last) ? (rep == 8'hFF ? rep : rep + 8'd1) : 8'd1;
    dsum = '0;
    for (int i = 0; i < NUM_CH; i++) dsum += (DROP_W + 1)'(drop[i]);
    dnext = {1'b0, bus.drop_cnt} + dsum;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      sh <= '0;
      rep <= '0;
      last <= 1'b0;
      bus.out_word <= '0;
      bus.out_valid <= 1'b0;
      bus.health_fail <= 1'b0;
      bus.drop_cnt <= '0;
    end else begin
      if (take) ptr <= gidx == PW'(NUM_CH - 1) ? '0 : gidx + 1'b1;
      sh <= sh_n;
      // a full word waiting on backpressure parks at cnt==WORD_W and stalls acceptance
      cnt <= ld_new ? '0 : cnt_n;
      if (ld_full || ld_new) begin
        bus.out_word <= ld_full ? sh : sh_n;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) bus.out_valid <= 1'b0;
      bus.drop_cnt <= dnext[DROP_W] ? '1 : dnext[DROP_W-1:0];
      if (bus.health_clr) begin
        rep <= '0;
        bus.health_fail <= 1'b0;
      end else if (take) begin
        rep <= rep_n;
        if (rep_n >= 8'(REPEAT_LIMIT)) bus.health_fail <= 1'b1;
      end
      if (take) last <= gbit;
    end
endmodule
